// File: rtl/ysyx_24100005_ifetch_resp.sv
// Instruction-fetch responder: word ROM behind a req/resp handshake with fixed latency.
// Optional IFETCH_TRACE_EN adds a handshake trace and a LATENCY range check.
module ysyx_24100005_ifetch_resp #(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  output logic [31:0]              resp_addr,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + 33'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     rom [DEPTH];

  logic [32:0]     addr33;
  logic            misaligned;
  logic            out_range;
  logic            fault;
  logic            accept;
  logic [IW-1:0]   idx;
  logic [31:0]     rom_q;

  // Range check in 33 bits so addresses near 2^32 cannot wrap into the window
  assign addr33     = {1'b0, req_addr};
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign out_range  = (addr33 < LO) || (addr33 >= HI);
  assign fault      = misaligned || out_range;
  assign idx        = IW'((req_addr - BASE) >> 2);
  assign rom_q      = rom[idx];
  assign accept     = req_valid && req_ready;

  // Load port; not reset, and a same-edge accept still reads the old word
  always_ff @(posedge clk) begin
    if (ld_en) begin
      rom[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_inst  <= 32'h0;
      resp_addr  <= 32'h0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            resp_addr <= req_addr;
            resp_err  <= fault;
            resp_inst <= fault ? ERR_INST : rom_q;
            if (LATENCY <= 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt <= CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // Re-accept only from the following cycle
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_TRACE_EN
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "ifetch: LATENCY %0d outside 1..15", LATENCY);
  end

  always_ff @(posedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      $display("ifetch addr=%h inst=%h err=%b", resp_addr, resp_inst, resp_err);
    end
  end
`else
`endif

endmodule

// File: tb/tb_ysyx_24100005_ifetch_resp.sv
// Bench for ysyx_24100005_ifetch_resp: three instances at LATENCY 1, 3 and 4 share one load port,
// checked against an array model of the ROM and the address/fault rules.
module tb_ysyx_24100005_ifetch_resp;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          DEPTH    = 1024;
  localparam logic [31:0] ERR_INST = 32'h0010_0073;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [31:0]      req_addr;
  logic [2:0]       resp_valid;
  logic [2:0]       resp_ready;
  logic [2:0][31:0] resp_inst;
  logic [2:0]       resp_err;
  logic [2:0][31:0] resp_addr;
  logic             ld_en;
  logic [9:0]       ld_idx;
  logic [31:0]      ld_data;

  logic [31:0] mem [DEPTH];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ysyx_24100005_ifetch_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_inst(resp_inst[0]),
    .resp_err(resp_err[0]), .resp_addr(resp_addr[0]), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

  ysyx_24100005_ifetch_resp #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_inst(resp_inst[1]),
    .resp_err(resp_err[1]), .resp_addr(resp_addr[1]), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

  ysyx_24100005_ifetch_resp #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_inst(resp_inst[2]),
    .resp_err(resp_err[2]), .resp_addr(resp_addr[2]), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Reference: fault if misaligned or outside [BASE, BASE+4*DEPTH) in wide arithmetic
  function automatic void model(input logic [31:0] a, output logic [31:0] inst, output logic err);
    longint unsigned la, lb;
    la  = 64'(a);
    lb  = 64'(BASE);
    err = (la % 4 != 0) || (la < lb) || (la >= lb + 4 * DEPTH);
    inst = err ? ERR_INST : mem[int'((la - lb) / 4)];
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (sel == 6) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    if (sel == 7) return 32'($urandom_range(0, 32'h7FFF_FFFF));
    if (sel == 8) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
    return 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
  endfunction

  task automatic load_word(input int i, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 10'(i); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mem[i] = d;
  endtask

  // Drives one fetch (optionally with a same-cycle load) and reports what came back
  task automatic do_fetch(input int k, input logic [31:0] a, input int stall, input bit do_ld,
                          input int li, input logic [31:0] ld,
                          output logic [31:0] inst, output logic err, output logic [31:0] ra,
                          output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    req_addr = a; req_valid[k] = 1'b1; resp_ready[k] = 1'b0;
    if (do_ld) begin ld_en = 1'b1; ld_idx = 10'(li); ld_data = ld; end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; ld_en = 1'b0; req_addr = $urandom;
    if (do_ld) mem[li] = ld;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[k] && lat < 40) begin @(negedge clk); lat++; end
    inst = resp_inst[k]; err = resp_err[k]; ra = resp_addr[k];
    repeat (stall) @(negedge clk);
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0)
        $display("FAIL reset_hs[%0d] ready=%b valid=%b want ready=1 valid=0", k, req_ready[k], resp_valid[k]);
      else pass_cnt++;
      chk_cnt++;
      if (resp_err[k] !== 1'b0 || resp_inst[k] !== 32'h0 || resp_addr[k] !== 32'h0)
        $display("FAIL reset_out[%0d] err=%b inst=%h addr=%h want 0/0/0", k, resp_err[k], resp_inst[k], resp_addr[k]);
      else pass_cnt++;
    end
  endtask

  task automatic init_rom();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 10'(i); ld_data = $urandom; mem[i] = ld_data;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] inst, ra; logic err; int lat;
    load_word(0, 32'h0000_0413);
    load_word(1, 32'h0010_0093);
    do_fetch(0, 32'h8000_0000, 0, 1'b0, 0, 32'h0, inst, err, ra, lat);
    chk_cnt++;
    if (inst !== 32'h0000_0413 || err !== 1'b0 || ra !== 32'h8000_0000 || lat != 1)
      $display("FAIL basic0 inst=%h err=%b addr=%h lat=%0d want 00000413/0/80000000/1", inst, err, ra, lat);
    else pass_cnt++;
    do_fetch(0, 32'h8000_0004, 0, 1'b0, 0, 32'h0, inst, err, ra, lat);
    chk_cnt++;
    if (inst !== 32'h0010_0093 || err !== 1'b0 || ra !== 32'h8000_0004 || lat != 1)
      $display("FAIL basic1 inst=%h err=%b addr=%h lat=%0d want 00100093/0/80000004/1", inst, err, ra, lat);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int lat;
    @(negedge clk);
    req_addr = 32'h8000_0004; req_valid[1] = 1'b1; resp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_addr = 32'h8000_0000;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[1] && lat < 40) begin
      chk_cnt++;
      if (req_ready[1] !== 1'b0) $display("FAIL stall_wait_ready got=%b want=0", req_ready[1]);
      else pass_cnt++;
      @(negedge clk); lat++;
    end
    chk_cnt++;
    if (lat != 3) $display("FAIL stall_latency got=%0d want=3", lat);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      chk_cnt++;
      if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 || resp_inst[1] !== 32'h0010_0093 ||
          resp_err[1] !== 1'b0 || resp_addr[1] !== 32'h8000_0004)
        $display("FAIL stall_hold[%0d] valid=%b ready=%b inst=%h err=%b addr=%h want 1/0/00100093/0/80000004",
                 c, resp_valid[1], req_ready[1], resp_inst[1], resp_err[1], resp_addr[1]);
      else pass_cnt++;
      @(negedge clk);
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
      $display("FAIL stall_release valid=%b ready=%b want 0/1", resp_valid[1], req_ready[1]);
    else pass_cnt++;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [5];
    logic [31:0] inst, ra, e_inst; logic err, e_err; int lat;
    addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000, 32'hFFFF_FFFC, 32'h8000_0FFC};
    for (int i = 0; i < 5; i++) begin
      model(addrs[i], e_inst, e_err);
      do_fetch(i % 3, addrs[i], 0, 1'b0, 0, 32'h0, inst, err, ra, lat);
      chk_cnt++;
      if (inst !== e_inst || err !== e_err || ra !== addrs[i] || lat != lat_of(i % 3))
        $display("FAIL fault[%h] inst=%h err=%b addr=%h lat=%0d want %h/%b/%h/%0d",
                 addrs[i], inst, err, ra, lat, e_inst, e_err, addrs[i], lat_of(i % 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_load_collision();
    logic [31:0] inst, ra, prior; logic err; int lat;
    prior = mem[2];
    do_fetch(0, 32'h8000_0008, 0, 1'b1, 2, 32'hDEAD_BEEF, inst, err, ra, lat);
    chk_cnt++;
    if (inst !== prior || err !== 1'b0)
      $display("FAIL collide_old inst=%h err=%b want %h/0", inst, err, prior);
    else pass_cnt++;
    do_fetch(1, 32'h8000_0008, 1, 1'b0, 0, 32'h0, inst, err, ra, lat);
    chk_cnt++;
    if (inst !== 32'hDEAD_BEEF || err !== 1'b0)
      $display("FAIL collide_new inst=%h err=%b want deadbeef/0", inst, err);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] inst, ra, e_inst; logic err, e_err; int lat; bit seen;
    @(negedge clk);
    req_addr = 32'h8000_0010; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0 || resp_inst[2] !== 32'h0 || resp_addr[2] !== 32'h0)
      $display("FAIL rstwait_state ready=%b valid=%b inst=%h addr=%h want 1/0/0/0",
               req_ready[2], resp_valid[2], resp_inst[2], resp_addr[2]);
    else pass_cnt++;
    seen = 1'b0;
    repeat (8) begin
      if (resp_valid[2]) seen = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL rstwait_dropped saw_valid=%b want 0", seen);
    else pass_cnt++;
    model(32'h8000_0014, e_inst, e_err);
    do_fetch(2, 32'h8000_0014, 0, 1'b0, 0, 32'h0, inst, err, ra, lat);
    chk_cnt++;
    if (inst !== e_inst || err !== e_err || lat != 4)
      $display("FAIL rstwait_next inst=%h err=%b lat=%0d want %h/%b/4", inst, err, lat, e_inst, e_err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] qi[$], qa[$]; logic qe[$];
    logic [31:0] e_inst; logic e_err;
    int accepts, resps;
    accepts = 0; resps = 0;
    @(negedge clk);
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr = rand_addr();
    for (int c = 0; c < 10; c++) begin
      if (resp_valid[0]) begin
        resps++;
        chk_cnt++;
        if (qi.size() == 0) $display("FAIL b2b_unexpected inst=%h want no response", resp_inst[0]);
        else if (resp_inst[0] !== qi[0] || resp_err[0] !== qe[0] || resp_addr[0] !== qa[0])
          $display("FAIL b2b_resp inst=%h err=%b addr=%h want %h/%b/%h",
                   resp_inst[0], resp_err[0], resp_addr[0], qi[0], qe[0], qa[0]);
        else pass_cnt++;
        if (qi.size() != 0) begin void'(qi.pop_front()); void'(qe.pop_front()); void'(qa.pop_front()); end
      end
      if (req_ready[0]) begin
        model(req_addr, e_inst, e_err);
        qi.push_back(e_inst); qe.push_back(e_err); qa.push_back(req_addr);
        accepts++;
      end
      @(posedge clk); #1;
      req_addr = rand_addr();
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    chk_cnt++;
    if (accepts != 5 || resps != 5 || qi.size() != 0)
      $display("FAIL b2b_throughput accepts=%0d resps=%0d left=%0d want 5/5/0", accepts, resps, qi.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, inst, ra, e_inst; logic err, e_err; int lat, k;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, DEPTH - 1), $urandom);
      k = $urandom_range(0, 2);
      a = rand_addr();
      model(a, e_inst, e_err);
      do_fetch(k, a, $urandom_range(0, 3), 1'b0, 0, 32'h0, inst, err, ra, lat);
      chk_cnt++;
      if (inst !== e_inst || err !== e_err || ra !== a || lat != lat_of(k))
        $display("FAIL rand[%0d] k=%0d addr=%h inst=%h err=%b raddr=%h lat=%0d want %h/%b/%h/%0d",
                 it, k, a, inst, err, ra, lat, e_inst, e_err, a, lat_of(k));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_addr = '0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    test_reset();
    init_rom();
    test_basic();
    test_stall();
    test_faults();
    test_load_collision();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
